// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite type definitions and helpers used by the bus arbiter, the
// AHB_TOP slave path and the verification bench.
//   htrans_t        : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t        : burst type (SINGLE..INCR16)
//   hsize_t         : transfer size
//   beats_minus_one : remaining-beat load value for a burst type
//   is_fixed_burst  : burst has a defined length (WRAPx/INCRx)
// -----------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_t;

  localparam int BEAT_CNT_W = 4;

  // Beats still to come after the NONSEQ beat. Undefined-length bursts
  // (SINGLE, INCR) load 0.
  function automatic logic [BEAT_CNT_W-1:0] beats_minus_one(hburst_t burst);
    logic [BEAT_CNT_W-1:0] n;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
      default:                      n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_fixed_burst(hburst_t burst);
    return !((burst == HBURST_SINGLE) || (burst == HBURST_INCR));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the request vector cyclically
// starting one position after the pointer; the pointer position itself is
// examined last, so a sole requester that already holds the pointer wins.
//   req_i   : request vector
//   ptr_i   : index of the most recent winner
//   win_o   : one-hot winner (all zero when nobody requests)
//   valid_o : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] win_o,
  output logic         valid_o
);

  int idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!valid_o && req_i[W'(idx)]) begin
        win_o[W'(idx)] = 1'b1;
        valid_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
// Round-robin AHB-Lite bus arbiter for up to four masters sharing one slave
// path. Ownership is held across fixed-length, undefined-length (INCR) and
// locked bursts; re-arbitration only happens at a burst boundary.
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   HBUSREQ       : per-master bus request
//   HLOCK         : per-master locked-transfer request
//   HTRANS/HBURST : transfer/burst type of the current address-phase owner
//   HREADY        : slave ready; nothing advances while low
//   HGRANT        : one-hot grant
//   HMASTER       : address-phase owner index
//   HMASTER_D     : data-phase owner index
//   HMASTLOCK     : current address phase is locked
// -----------------------------------------------------------------------------
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK
);

  htrans_t trans;
  hburst_t burst;

  assign trans = htrans_t'(HTRANS);
  assign burst = hburst_t'(HBURST);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [MW-1:0]          data_owner_q, data_owner_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic                   mastlock_q, mastlock_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [NUM_MASTERS-1:0] pick_win;
  logic                   pick_valid;
  logic [MW-1:0]          pick_idx;

  logic accept_nonseq;
  logic accept_seq;
  logic burst_last;
  logic incr_release;
  logic arb;

  rr_picker #(
    .N (NUM_MASTERS),
    .W (MW)
  ) u_picker (
    .req_i   (HBUSREQ),
    .ptr_i   (ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_win[i]) begin
        pick_idx = MW'(i);
      end
    end
  end

  always_comb begin
    accept_nonseq = HREADY && (trans == HTRANS_NONSEQ);
    accept_seq    = HREADY && (trans == HTRANS_SEQ);

    // Remaining-beat counter; SEQ past the end saturates at zero.
    beat_cnt_d = beat_cnt_q;
    if (accept_nonseq) begin
      beat_cnt_d = beats_minus_one(burst);
    end else if (accept_seq && (beat_cnt_q != '0)) begin
      beat_cnt_d = beat_cnt_q - 4'd1;
    end

    // A fixed burst ends on the beat that brings the counter to zero. A
    // NONSEQ of a fixed burst always loads a non-zero count, so only SEQ can
    // end it in practice.
    burst_last = (accept_nonseq && (burst == HBURST_SINGLE)) ||
                 ((accept_nonseq || accept_seq) && is_fixed_burst(burst) &&
                  (beat_cnt_d == '0));

    // An INCR burst has no length; it ends when its owner stops requesting.
    incr_release = (burst == HBURST_INCR) && !HBUSREQ[owner_q];

    arb = HREADY && !HLOCK[owner_q] && (trans != HTRANS_BUSY) &&
          ((trans == HTRANS_IDLE) || burst_last || incr_release);

    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (arb) begin
      if (pick_valid) begin
        grant_d = pick_win;
        owner_d = pick_idx;
        ptr_d   = pick_idx;
      end else begin
        // Park on master 0; the pointer keeps its place in the rotation.
        grant_d = NUM_MASTERS'(1);
        owner_d = '0;
      end
    end

    data_owner_d = HREADY ? owner_q        : data_owner_q;
    mastlock_d   = HREADY ? HLOCK[owner_q] : mastlock_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q      <= NUM_MASTERS'(1);
      owner_q      <= '0;
      data_owner_q <= '0;
      ptr_q        <= '0;
      mastlock_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      ptr_q        <= ptr_d;
      mastlock_q   <= mastlock_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = owner_q;
  assign HMASTER_D = data_owner_q;
  assign HMASTLOCK = mastlock_q;

endmodule
